// File: rtl/ahblite_dma_master.sv
// Single-channel AHB-lite DMA master that copies len words src->dst, one read and then one write per word.
// Define DMA_IRQ_EN to build the sticky completion interrupt; otherwise irq is tied low.
module ahblite_dma_master #(
   parameter int LEN_W = 16
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             irq,
   input  logic             irq_clr,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic             HMASTLOCK,
   output logic [31:0]      HWDATA,
   input  logic [31:0]      HRDATA,
   input  logic             HREADY,
   input  logic             HRESP
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_ADDR = 3'd3,
      S_WR_DATA = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   state_t           state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [31:0]      haddr_q, haddr_d;
   logic [1:0]       htrans_q, htrans_d;
   logic             hwrite_q, hwrite_d;
   logic [31:0]      hwdata_q, hwdata_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         cnt_q    <= '0;
         haddr_q  <= '0;
         htrans_q <= TR_IDLE;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         cnt_q    <= cnt_d;
         haddr_q  <= haddr_d;
         htrans_q <= htrans_d;
         hwrite_q <= hwrite_d;
         hwdata_q <= hwdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // hwdata_q doubles as the word buffer: loaded on a good read, untouched until the next one.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      cnt_d    = cnt_q;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hwdata_d = hwdata_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d = src_addr & 32'hFFFF_FFFC;
               dst_d = dst_addr & 32'hFFFF_FFFC;
               cnt_d = len;
               err_d = 1'b0;
               if (len == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d  = S_RD_ADDR;
                  haddr_d  = src_addr & 32'hFFFF_FFFC;
                  hwrite_d = 1'b0;
               end
            end
         end
         S_RD_ADDR: begin
            if (HREADY) state_d = S_RD_DATA;
         end
         S_RD_DATA: begin
            if (HREADY) begin
               if (HRESP) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  hwdata_d = HRDATA;
                  state_d  = S_WR_ADDR;
                  haddr_d  = dst_q;
                  hwrite_d = 1'b1;
               end
            end
         end
         S_WR_ADDR: begin
            if (HREADY) state_d = S_WR_DATA;
         end
         S_WR_DATA: begin
            if (HREADY) begin
               if (HRESP) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  src_d = src_q + 32'd4;
                  dst_d = dst_q + 32'd4;
                  cnt_d = cnt_q - LEN_W'(1);
                  if (cnt_q == LEN_W'(1)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d  = S_RD_ADDR;
                     haddr_d  = src_q + 32'd4;
                     hwrite_d = 1'b0;
                  end
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      htrans_d = (state_d == S_RD_ADDR || state_d == S_WR_ADDR) ? TR_NONSEQ : TR_IDLE;
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
   end

`ifdef DMA_IRQ_EN
   logic irq_q, irq_d;

   // Set is asserted both entering and during DONE so a coincident clear loses.
   always_comb begin
      irq_d = irq_q;
      if (irq_clr) irq_d = 1'b0;
      if (state_d == S_DONE || state_q == S_DONE) irq_d = 1'b1;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) irq_q <= 1'b0;
      else          irq_q <= irq_d;
   end

   assign irq = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = irq_clr;
   assign irq = 1'b0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign HADDR     = haddr_q;
   assign HTRANS    = htrans_q;
   assign HWRITE    = hwrite_q;
   assign HWDATA    = hwdata_q;
   assign HSIZE     = 3'b010;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahblite_dma_master.sv
// Bench for ahblite_dma_master: random-wait AHB slave plus a transaction/timing model of each request.
module tb_ahblite_dma_master;
   localparam int LEN_W = 16;

   logic HCLK, HRESETn, start, irq_clr, busy, done, err, irq;
   logic [31:0] src_addr, dst_addr, HADDR, HWDATA, HRDATA;
   logic [LEN_W-1:0] len;
   logic [1:0] HTRANS;
   logic [2:0] HSIZE, HBURST;
   logic [3:0] HPROT;
   logic HWRITE, HMASTLOCK, HREADY, HRESP;

   ahblite_dma_master #(.LEN_W(LEN_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len(len), .busy(busy), .done(done), .err(err), .irq(irq), .irq_clr(irq_clr),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP));

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
      logic        er;
   } xfer_t;

   xfer_t obs_q[$];
   bit [31:0] mem [bit [31:0]];
   int as_tab[256];
   int dw_tab[256];
   int err_abs = -1;
   int pidx = 0;

   int n_tests = 0, n_fail = 0;
   logic exp_irq = 1'b0;
   logic have_last = 1'b0;
   logic [31:0] last_addr = '0;
   logic last_wr = 1'b0;

   // AHB slave: per-phase address stalls / data waits / error come from the tables above.
   logic d_act = 0, a_act = 0, d_err = 0, d_wr = 0;
   int d_wait = 0, a_stall = 0, d_estg = 0;
   logic [31:0] d_addr = '0;
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         d_act = 0; a_act = 0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      end else if (d_act) begin
         if (d_wait > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom; d_wait--;
         end else if (d_err && d_estg == 0) begin
            HREADY = 1'b0; HRESP = 1'b1; d_estg = 1;
         end else if (d_err) begin
            HREADY = 1'b1; HRESP = 1'b1;
            obs_q.push_back('{d_addr, d_wr, 32'h0, 1'b1});
            d_act = 0;
         end else begin
            HREADY = 1'b1; HRESP = 1'b0;
            if (d_wr) obs_q.push_back('{d_addr, 1'b1, HWDATA, 1'b0});
            else begin
               HRDATA = mem[d_addr];
               obs_q.push_back('{d_addr, 1'b0, mem[d_addr], 1'b0});
            end
            d_act = 0;
         end
      end else if (HTRANS == 2'b10) begin
         HRESP = 1'b0;
         if (!a_act) begin a_act = 1; a_stall = as_tab[pidx & 255]; end
         if (a_stall > 0) begin
            HREADY = 1'b0; a_stall--;
         end else begin
            HREADY = 1'b1; a_act = 0; d_act = 1;
            d_wait = dw_tab[pidx & 255]; d_err = (pidx == err_abs); d_estg = 0;
            d_addr = HADDR; d_wr = HWRITE;
            pidx++;
         end
      end else begin
         HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Advance to the next negedge and check the always-true bus rules.
   task automatic tick();
      @(negedge HCLK);
      if (HRESETn) begin
         chk("const_ctrl", {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
         chk("htrans_legal", (HTRANS == 2'b00 || HTRANS == 2'b10), 1);
         if (HTRANS == 2'b10) begin
            last_addr = HADDR; last_wr = HWRITE; have_last = 1'b1;
         end else if (busy && have_last) begin
            chk("haddr_hold", HADDR, last_addr);
            chk("hwrite_hold", HWRITE, last_wr);
         end
`ifndef DMA_IRQ_EN
         chk("irq_tied", irq, 0);
`endif
      end
   endtask

   task automatic run_req(input logic [31:0] src, input logic [31:0] dst, input int n, input int ep,
                          input int alo, input int ahi, input int wlo, input int whi,
                          input logic [31:0] w0, output int got_done, output int n_wr);
      xfer_t exp_q[$];
      int base, ob, s_cyc, done_cyc, k;
      logic exp_err, clr_prev, done_prev;
      logic [31:0] sa, da, d;
      base = pidx;
      ob = obs_q.size();
      sa = src & 32'hFFFF_FFFC;
      da = dst & 32'hFFFF_FFFC;
      for (int i = 0; i < 2 * n; i++) begin
         as_tab[(base + i) & 255] = $urandom_range(ahi, alo);
         dw_tab[(base + i) & 255] = $urandom_range(whi, wlo);
      end
      err_abs = (ep < 0) ? -1 : base + ep;
      // Model: each phase costs 1 + stalls (address) or 1 + waits (data, +1 for the error cycle).
      s_cyc = 0; exp_err = 1'b0;
      for (int w = 0; w < n; w++) begin
         d = (w == 0) ? w0 : $urandom;
         mem[sa + 32'(4 * w)] = d;
         k = 2 * w;
         s_cyc += 1 + as_tab[(base + k) & 255];
         if (k == ep) begin
            s_cyc += 2 + dw_tab[(base + k) & 255];
            exp_q.push_back('{sa + 32'(4 * w), 1'b0, 32'h0, 1'b1}); exp_err = 1'b1; break;
         end
         s_cyc += 1 + dw_tab[(base + k) & 255];
         exp_q.push_back('{sa + 32'(4 * w), 1'b0, d, 1'b0});
         k = 2 * w + 1;
         s_cyc += 1 + as_tab[(base + k) & 255];
         if (k == ep) begin
            s_cyc += 2 + dw_tab[(base + k) & 255];
            exp_q.push_back('{da + 32'(4 * w), 1'b1, 32'h0, 1'b1}); exp_err = 1'b1; break;
         end
         s_cyc += 1 + dw_tab[(base + k) & 255];
         exp_q.push_back('{da + 32'(4 * w), 1'b1, d, 1'b0});
      end
      done_cyc = s_cyc + 1;

      tick();
      start = 1'b1; src_addr = src; dst_addr = dst; len = LEN_W'(n);
      clr_prev = 1'b0; done_prev = 1'b0; got_done = -1;
      for (int rel = 1; rel <= done_cyc + 1; rel++) begin
         tick();
         start = (rel == done_cyc) || (rel == 2 && rel < done_cyc);
         if (start) begin src_addr = ~src; dst_addr = $urandom; len = LEN_W'(n + 1); end
         if (done && got_done < 0) got_done = rel;
         chk("busy", busy, rel <= done_cyc);
         chk("done", done, rel == done_cyc);
         chk("err", err, (rel >= done_cyc) ? exp_err : 1'b0);
`ifdef DMA_IRQ_EN
         if (clr_prev && !done_prev) exp_irq = 1'b0;
         if (rel == done_cyc) exp_irq = 1'b1;
         chk("irq", irq, exp_irq);
`endif
         done_prev = (rel == done_cyc);
         irq_clr = ($urandom_range(2, 0) == 0);
         clr_prev = irq_clr;
      end
      start = 1'b0; irq_clr = 1'b0;

      n_wr = 0;
      chk("n_xfers", obs_q.size() - ob, exp_q.size());
      for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
         chk("x_addr", obs_q[ob + i].addr, exp_q[i].addr);
         chk("x_dir", obs_q[ob + i].wr, exp_q[i].wr);
         chk("x_err", obs_q[ob + i].er, exp_q[i].er);
         if (!exp_q[i].er) chk("x_data", obs_q[ob + i].data, exp_q[i].data);
      end
      for (int i = ob; i < obs_q.size(); i++)
         if (obs_q[i].wr && !obs_q[i].er) n_wr++;
   endtask

   initial begin
      int gd, nw, n, ep;
      logic [31:0] s;
      HRESETn = 1'b0; start = 1'b0; irq_clr = 1'b0;
      src_addr = '0; dst_addr = '0; len = '0;
      repeat (3) tick();
      chk("rst_haddr", HADDR, 0);
      chk("rst_htrans", HTRANS, 0);
      chk("rst_hwrite", HWRITE, 0);
      chk("rst_hwdata", HWDATA, 0);
      chk("rst_flags", {busy, done, err, irq}, 0);
      chk("rst_const", {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
      HRESETn = 1'b1;

      // Single word, no waits.
      run_req(32'h2000_0000, 32'h2000_0100, 1, -1, 0, 0, 0, 0, 32'hDEAD_BEEF, gd, nw);
      chk("t1_done_cycle", gd, 5);
      chk("t1_writes", nw, 1);
      chk("t1_waddr", obs_q[obs_q.size() - 1].addr, 32'h2000_0100);
      chk("t1_wdata", obs_q[obs_q.size() - 1].data, 32'hDEAD_BEEF);
      chk("t1_err", err, 0);

      // Four words, two wait states on every data phase.
      run_req(32'h2000_0000, 32'h2000_0040, 4, -1, 0, 0, 2, 2, $urandom, gd, nw);
      chk("t2_writes", nw, 4);

      // Zero-length request.
      run_req(32'h2000_0000, 32'h2000_0040, 0, -1, 0, 0, 0, 0, $urandom, gd, nw);
      chk("t3_done_cycle", gd, 1);
      chk("t3_writes", nw, 0);

      // Error on the second read (phase index 2).
      run_req(32'h2000_0000, 32'h2000_0100, 3, 2, 0, 0, 0, 1, $urandom, gd, nw);
      chk("t4_writes", nw, 1);
      chk("t4_err_sticky", err, 1);

      // Next accepted start clears err (checked cycle-by-cycle inside run_req).
      run_req(32'h2000_0200, 32'h2000_0300, 2, -1, 0, 1, 0, 2, $urandom, gd, nw);
      chk("t5_writes", nw, 2);

      // Randomized requests, including unaligned addresses and 2^32 wrap.
      for (int t = 0; t < 20; t++) begin
         s = (t % 4 == 3) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
         n = $urandom_range(6, 0);
         ep = (n > 0 && $urandom_range(2, 0) == 0) ? $urandom_range(2 * n - 1, 0) : -1;
         run_req(s, s + 32'h1000_0000 + 32'($urandom_range(3, 0)), n, ep, 0, 1, 0, 3, $urandom, gd, nw);
      end

      // Start while busy, then reset in the middle of a write data phase.
      for (int i = 0; i < 8; i++) begin
         as_tab[(pidx + i) & 255] = 0;
         dw_tab[(pidx + i) & 255] = 0;
      end
      err_abs = -1;
      tick(); start = 1'b1; src_addr = 32'h3000_0000; dst_addr = 32'h3000_0100; len = LEN_W'(3);
      tick(); start = 1'b0;
      tick(); start = 1'b1; src_addr = 32'h4000_0000; len = LEN_W'(7);
      tick(); start = 1'b0;
      chk("r_wr_addr", {HTRANS, HWRITE}, {2'b10, 1'b1});
      chk("r_wr_haddr", HADDR, 32'h3000_0100);
      tick();
      chk("r_wr_data", {HTRANS, HWRITE}, {2'b00, 1'b1});
      HRESETn = 1'b0;
      #1;
      chk("r_htrans", HTRANS, 0);
      chk("r_haddr", HADDR, 0);
      chk("r_hwrite", HWRITE, 0);
      chk("r_hwdata", HWDATA, 0);
      chk("r_flags", {busy, done, err, irq}, 0);
      exp_irq = 1'b0; have_last = 1'b0;
      tick(); tick();
      HRESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("r_idle_after", {busy, HTRANS}, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
